// File: rtl/opb_register_bank.sv
// OPB slave register bank: N_REGS 32-bit user registers plus a control word,
// with optional shadow/commit so several registers can be loaded on one edge.
module opb_register_bank #(
  parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR = 32'h0000_00FF,
  parameter int unsigned N_REGS     = 4,
  parameter bit          C_SHADOW   = 1'b0
) (
  input  logic                   OPB_Clk,
  input  logic                   OPB_Rst_n,
  input  logic [0:31]            OPB_ABus,
  input  logic [0:3]             OPB_BE,
  input  logic [0:31]            OPB_DBus,
  input  logic                   OPB_RNW,
  input  logic                   OPB_select,
  input  logic                   OPB_seqAddr,
  output logic [0:31]            Sl_DBus,
  output logic                   Sl_xferAck,
  output logic                   Sl_errAck,
  output logic                   Sl_retry,
  output logic                   Sl_toutSup,
  output logic [N_REGS*32-1:0]   user_data_out,
  output logic [N_REGS-1:0]      user_update
);

  localparam logic [29:0] LP_CTL = 30'(N_REGS);

  logic        r_rst_q;
  logic        r_busy;
  logic        r_ack;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_data   [N_REGS];
  logic [31:0] r_shadow [N_REGS];
  logic [N_REGS-1:0] r_pending;
  logic [N_REGS-1:0] r_update;

  logic [31:0] w_abus, w_wdata, w_off, w_mask, w_rd_reg, w_ctl_rd;
  logic [29:0] w_word;
  logic [N_REGS-1:0] w_sel;
  logic w_hit, w_accept, w_is_ctl, w_is_err, w_wr, w_commit;
  logic w_unused;

  // Buses are [0:31] with bit 0 as MSB, so plain assignment keeps numeric value.
  always_comb begin
    w_abus   = OPB_ABus;
    w_wdata  = OPB_DBus;
    w_off    = w_abus - C_BASEADDR;
    w_word   = w_off[31:2];
    w_hit    = OPB_select && (w_abus >= C_BASEADDR) && (w_abus <= C_HIGHADDR);
    w_accept = w_hit && r_rst_q && !r_busy;
    w_is_ctl = (w_word == LP_CTL);
    w_is_err = (w_word > LP_CTL);
    w_mask   = {{8{OPB_BE[0]}}, {8{OPB_BE[1]}}, {8{OPB_BE[2]}}, {8{OPB_BE[3]}}};
    w_sel    = '0;
    w_rd_reg = '0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      if (w_word == 30'(i)) begin
        w_sel[i] = 1'b1;
        w_rd_reg = C_SHADOW ? r_shadow[i] : r_data[i];
      end
    end
    w_ctl_rd = '0;
    if (C_SHADOW) begin
      for (int unsigned i = 0; i < N_REGS; i++) w_ctl_rd[31-i] = r_pending[i];
    end
    w_wr     = w_accept && !OPB_RNW && (OPB_BE != '0);
    w_commit = C_SHADOW && w_accept && !OPB_RNW && w_is_ctl && OPB_BE[3] && w_wdata[0];
    w_unused = ^{OPB_seqAddr, w_off[1:0]};
  end

  // Single stage: a hit is first accepted on the second edge after reset release.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) r_rst_q <= 1'b0;
    else            r_rst_q <= 1'b1;
  end

  // r_busy holds off re-acceptance until the master drops select.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_busy  <= OPB_select && (r_busy || w_accept);
      r_ack   <= w_accept;
      r_err   <= w_accept && w_is_err;
      r_rdata <= '0;
      if (w_accept && OPB_RNW) r_rdata <= w_is_ctl ? w_ctl_rd : w_rd_reg;
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      for (int unsigned i = 0; i < N_REGS; i++) begin
        r_data[i]   <= '0;
        r_shadow[i] <= '0;
      end
      r_pending <= '0;
      r_update  <= '0;
    end else begin
      r_update <= '0;
      for (int unsigned i = 0; i < N_REGS; i++) begin
        if (w_wr && w_sel[i]) begin
          if (C_SHADOW) begin
            r_shadow[i]  <= (r_shadow[i] & ~w_mask) | (w_wdata & w_mask);
            r_pending[i] <= 1'b1;
          end else begin
            r_data[i]   <= (r_data[i] & ~w_mask) | (w_wdata & w_mask);
            r_update[i] <= 1'b1;
          end
        end
      end
      if (w_commit) begin
        for (int unsigned i = 0; i < N_REGS; i++) begin
          if (r_pending[i]) r_data[i] <= r_shadow[i];
        end
        r_update  <= r_pending;
        r_pending <= '0;
      end
    end
  end

  for (genvar g = 0; g < N_REGS; g++) begin : g_out
    assign user_data_out[32*g +: 32] = r_data[g];
  end

  assign user_update = r_update;
  assign Sl_DBus     = r_rdata;
  assign Sl_xferAck  = r_ack;
  assign Sl_errAck   = r_err;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;

endmodule

// File: tb/tb_opb_register_bank.sv
// Scoreboarded bench: an immediate-mode and a shadow-mode bank share one OPB bus
// at different base addresses; a negedge monitor checks every ack against a queue.
module tb_opb_register_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [0:31] abus, dbus_in;
  logic [0:3]  be;
  logic        rnw, sel, seq;
  logic [0:31] dbus_i, dbus_s;
  logic        ack_i, err_i, rty_i, tos_i, ack_s, err_s, rty_s, tos_s;
  logic [127:0] uo_i, uo_s;
  logic [3:0]   upd_i, upd_s;

  opb_register_bank #(
    .C_BASEADDR(32'h0000_1000), .C_HIGHADDR(32'h0000_10FF), .N_REGS(4), .C_SHADOW(1'b0)
  ) u_imm (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus_in),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(dbus_i),
    .Sl_xferAck(ack_i), .Sl_errAck(err_i), .Sl_retry(rty_i), .Sl_toutSup(tos_i),
    .user_data_out(uo_i), .user_update(upd_i)
  );

  opb_register_bank #(
    .C_BASEADDR(32'h0000_2000), .C_HIGHADDR(32'h0000_20FF), .N_REGS(4), .C_SHADOW(1'b1)
  ) u_shd (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus_in),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(dbus_s),
    .Sl_xferAck(ack_s), .Sl_errAck(err_s), .Sl_retry(rty_s), .Sl_toutSup(tos_s),
    .user_data_out(uo_s), .user_update(upd_s)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t q_i[$];
  exp_t q_s[$];
  int n_err = 0;
  int n_chk = 0;

  logic [3:0]   cap_upd_i, cap_upd_s;
  logic [127:0] cap_uo_i, cap_uo_s;
  logic         cap_ack_i, cap_ack_s;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops one expectation; idle cycles must show a quiet bus.
  always @(negedge clk) begin : mon
    exp_t e;
    if (ack_i) begin
      if (q_i.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL imm_unexpected_ack: got ack=1 expected no ack");
      end else begin
        e = q_i.pop_front();
        chk("imm_rd_data", dbus_i, e.data);
        chk("imm_errack", err_i, e.err);
      end
    end else chk("imm_idle_bus", {dbus_i, err_i}, '0);
    if (ack_s) begin
      if (q_s.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL shd_unexpected_ack: got ack=1 expected no ack");
      end else begin
        e = q_s.pop_front();
        chk("shd_rd_data", dbus_s, e.data);
        chk("shd_errack", err_s, e.err);
      end
    end else chk("shd_idle_bus", {dbus_s, err_s}, '0);
  end

  // tgt: 0 = immediate bank acks, 1 = shadow bank acks, 2 = nobody acks
  task automatic xfer(input logic [31:0] addr, input logic r, input logic [31:0] d,
                      input logic [3:0] b, input int tgt, input logic [31:0] erd,
                      input logic eerr);
    exp_t e;
    e.data = erd;
    e.err  = eerr;
    if (tgt == 0) q_i.push_back(e);
    else if (tgt == 1) q_s.push_back(e);
    abus = addr; rnw = r; dbus_in = d; be = b; sel = 1'b1;
    @(negedge clk);
    cap_upd_i = upd_i; cap_upd_s = upd_s;
    cap_uo_i  = uo_i;  cap_uo_s  = uo_s;
    cap_ack_i = ack_i; cap_ack_s = ack_s;
    sel = 1'b0; rnw = 1'b1; dbus_in = '0; be = '0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] b,
                    input int tgt, input logic eerr);
    xfer(addr, 1'b0, d, b, tgt, 32'h0, eerr);
  endtask

  task automatic rd(input logic [31:0] addr, input int tgt, input logic [31:0] erd,
                    input logic eerr);
    xfer(addr, 1'b1, 32'h0, 4'h0, tgt, erd, eerr);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int acks;
    abus = '0; dbus_in = '0; be = '0; rnw = 1'b1; sel = 1'b0; seq = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {uo_i, uo_s}, '0);
    chk("reset_flags", {upd_i, upd_s, ack_i, ack_s, rty_i, tos_i, rty_s, tos_s}, '0);

    // Release reset with a hit already presented: accepted on the second edge
    e.data = 32'h0; e.err = 1'b0;
    q_i.push_back(e);
    rst_n = 1'b1;
    abus = 32'h1000; rnw = 1'b0; dbus_in = 32'h0000_0055; be = 4'hF; sel = 1'b1;
    @(negedge clk);
    chk("rst_sync_no_ack_edge1", ack_i, 1'b0);
    @(negedge clk);
    chk("rst_sync_ack_edge2", ack_i, 1'b1);
    sel = 1'b0; rnw = 1'b1; be = '0; dbus_in = '0;
    @(negedge clk);
    chk("rst_sync_write", uo_i[31:0], 32'h0000_0055);

    // Immediate full-word write and readback
    wr(32'h1008, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
    chk("imm_ack_cycle_slice2", cap_uo_i[95:64], 32'hDEAD_BEEF);
    chk("imm_ack_cycle_update", cap_upd_i, 4'b0100);
    chk("imm_update_one_cycle", upd_i, 4'b0000);
    rd(32'h1008, 0, 32'hDEAD_BEEF, 1'b0);

    // Byte enables: BE=0101 updates bytes 1 and 3 only
    wr(32'h1000, 32'h1122_3344, 4'hF, 0, 1'b0);
    wr(32'h1000, 32'hAABB_CCDD, 4'b0101, 0, 1'b0);
    chk("imm_be_slice0", uo_i[31:0], 32'h11BB_33DD);
    rd(32'h1000, 0, 32'h11BB_33DD, 1'b0);

    // BE=0000 is acked but changes nothing
    wr(32'h1004, 32'hFFFF_FFFF, 4'h0, 0, 1'b0);
    chk("imm_be0_no_update", cap_upd_i, 4'b0000);
    chk("imm_be0_slice1", uo_i[63:32], 32'h0);

    // Control word in immediate mode: acked, ignored, reads 0
    wr(32'h1010, 32'h0000_0001, 4'hF, 0, 1'b0);
    chk("imm_ctl_no_update", cap_upd_i, 4'b0000);
    rd(32'h1010, 0, 32'h0, 1'b0);

    // Out-of-map offset 7 and out-of-window addresses
    wr(32'h101C, 32'hFFFF_FFFF, 4'hF, 0, 1'b1);
    rd(32'h101C, 0, 32'h0, 1'b1);
    chk("imm_err_no_change", uo_i, {32'h0, 32'hDEAD_BEEF, 32'h0, 32'h11BB_33DD});
    wr(32'h1100, 32'hFFFF_FFFF, 4'hF, 2, 1'b0);
    chk("outside_high_no_ack", {cap_ack_i, cap_ack_s}, 2'b00);
    wr(32'h0FFC, 32'hFFFF_FFFF, 4'hF, 2, 1'b0);
    chk("outside_low_no_ack", {cap_ack_i, cap_ack_s}, 2'b00);
    chk("outside_no_change", uo_i, {32'h0, 32'hDEAD_BEEF, 32'h0, 32'h11BB_33DD});

    // Select held for three cycles yields exactly one ack
    e.data = 32'h0; e.err = 1'b0;
    q_i.push_back(e);
    abus = 32'h100C; rnw = 1'b0; dbus_in = 32'h1234_5678; be = 4'hF; sel = 1'b1;
    acks = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      acks += int'(ack_i);
    end
    sel = 1'b0; rnw = 1'b1; be = '0; dbus_in = '0;
    @(negedge clk);
    chk("held_select_one_ack", acks, 1);
    chk("held_select_data", uo_i, {32'h1234_5678, 32'hDEAD_BEEF, 32'h0, 32'h11BB_33DD});

    // Shadow mode: stage two registers, then commit together
    wr(32'h2000, 32'hA0A0_A0A0, 4'hF, 1, 1'b0);
    wr(32'h200C, 32'h0C0C_0C0C, 4'hF, 1, 1'b0);
    chk("shd_stage_no_update", cap_upd_s, 4'b0000);
    chk("shd_stage_outputs_unchanged", uo_s, '0);
    rd(32'h2000, 1, 32'hA0A0_A0A0, 1'b0);
    rd(32'h2010, 1, 32'h9000_0000, 1'b0);
    wr(32'h2010, 32'h0000_0001, 4'hF, 1, 1'b0);
    chk("shd_commit_update", cap_upd_s, 4'b1001);
    chk("shd_commit_outputs", cap_uo_s, {32'h0C0C_0C0C, 32'h0, 32'h0, 32'hA0A0_A0A0});
    chk("shd_update_one_cycle", upd_s, 4'b0000);
    rd(32'h2010, 1, 32'h0, 1'b0);
    wr(32'h2010, 32'h0000_0001, 4'hF, 1, 1'b0);
    chk("shd_empty_commit_no_pulse", cap_upd_s, 4'b0000);
    wr(32'h2004, 32'hFFFF_FFFF, 4'h0, 1, 1'b0);
    rd(32'h2010, 1, 32'h0, 1'b0);

    // Reset pulsed between hit and ack: no ack, everything cleared at once
    abus = 32'h1004; rnw = 1'b0; dbus_in = 32'h7777_7777; be = 4'hF; sel = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_clear", {uo_i, uo_s}, '0);
    chk("async_reset_flags", {upd_i, upd_s, ack_i, ack_s, dbus_i, dbus_s}, '0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_mid_no_ack", {ack_i, ack_s}, 2'b00);
    sel = 1'b0; rnw = 1'b1; be = '0; dbus_in = '0;
    @(negedge clk);
    chk("reset_mid_write_discarded", {uo_i, uo_s, upd_i, upd_s}, '0);
    rd(32'h2010, 1, 32'h0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q_i.size() + q_s.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/opb_register_bank.md
OPB_REGISTER_BANK -- requirements
Module: opb_register_bank

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h00000000, OPB base address of the bank.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h000000FF, OPB high address of the bank; window SHALL be at least (N_REGS+1)*4 bytes.
REQ-003 SHALL have parameter N_REGS, default 4, register count, legal range 1..32.
REQ-004 SHALL have parameter C_SHADOW, default 0; 0 = immediate mode, 1 = shadow/commit mode.
REQ-005 SHALL have port OPB_Clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port OPB_Rst_n, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have ports OPB_ABus in 32, OPB_BE in 4, OPB_DBus in 32, OPB_RNW in 1, OPB_select in 1, OPB_seqAddr in 1 (ignored); all OPB buses numbered [0:31], bit 0 = MSB.
REQ-008 SHALL have ports Sl_DBus out 32, Sl_xferAck out 1, Sl_errAck out 1, Sl_retry out 1, Sl_toutSup out 1.
REQ-009 SHALL have port user_data_out, output, N_REGS*32, register i at bits [32*i+31:32*i], OPB_DBus[0] mapped to bit 32*i+31.
REQ-010 SHALL have port user_update, output, N_REGS, one-cycle pulse per register when its user_data_out slice is loaded.

Function
REQ-011 Hit SHALL be OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR; word offset = (OPB_ABus - C_BASEADDR) >> 2.
REQ-012 Sl_xferAck SHALL assert for exactly one cycle, the cycle after a hit is first sampled; no ack is generated in the cycle following an ack (single-beat only, latency 1).
REQ-013 Sl_DBus SHALL be all-zero except in a read ack cycle.
REQ-014 Offsets 0..N_REGS-1 SHALL address data registers; read returns the visible value (immediate mode) or shadow value (shadow mode).
REQ-015 Writes SHALL honour byte enables: OPB_BE[k] enables OPB_DBus[8k:8k+7]; disabled bytes unchanged.
REQ-016 Immediate mode: write SHALL update user_data_out slice i on the ack clock edge; user_update[i] SHALL pulse the following cycle, concurrent with the new value.
REQ-017 Shadow mode: write SHALL update shadow i only and set pending[i]; user_data_out unchanged.
REQ-018 Offset N_REGS SHALL be control: write with OPB_DBus[31]=1 (BE[3]=1) commits; read returns pending bitmap in bits [32-N_REGS:31] (pending[i] at bit 31-i), other bits 0.
REQ-019 Commit SHALL copy all pending shadows to user_data_out on one edge, pulse user_update for exactly the pending set, clear pending; commit with nothing pending SHALL produce no pulse.
REQ-020 In immediate mode the control write SHALL be acked and ignored; control read SHALL return 0.
REQ-021 Offset > N_REGS inside window SHALL ack with Sl_errAck=1 in same cycle, read data 0, no state change.
REQ-022 Sl_retry and Sl_toutSup SHALL be constant 0.
REQ-023 OPB_select dropping before ack SHALL abort: no ack, no state change.
REQ-024 Writes SHALL be blocked entirely when OPB_BE=0000 yet still acked; pending SHALL not set.

Reset
REQ-025 While OPB_Rst_n=0: user_data_out, shadows, pending, user_update, Sl_DBus, Sl_xferAck, Sl_errAck SHALL be 0, immediately (asynchronous).
REQ-026 Deassertion of reset SHALL be synchronised internally; first hit SHALL be accepted on the second rising edge after deassertion.
REQ-027 Reset asserted mid-transaction SHALL suppress the pending ack and discard the write.

Verification
REQ-028 Immediate, N_REGS=4: write 0xDEADBEEF BE=1111 to offset 2 -> ack 1 cycle later, slice [95:64]=0xDEADBEEF, user_update=0100 one cycle; readback 0xDEADBEEF.
REQ-029 Byte enables: reg0=0x11223344, write 0xAABBCCDD BE=0101 -> reg0=0x11BB33DD.
REQ-030 Shadow mode: write regs 0 and 3, read control -> 0x90000000; user_data_out unchanged; commit -> both slices load on same edge, user_update=1001 one cycle, control reads 0.
REQ-031 Out-of-map offset 7 with N_REGS=4 -> Sl_xferAck=Sl_errAck=1 same cycle, Sl_DBus=0, no output change; address outside window -> no ack.
REQ-032 Select held 3 cycles -> exactly one ack; OPB_Rst_n pulsed low between hit and ack -> no ack, all outputs 0.
